sram_word_responder: RTL and testbench



---
 rtl/sram_ctrl_pkg.sv | 15 +
 rtl/sram_wait_counter.sv | 24 ++
 rtl/sram_word_responder.sv | 133 +++++++++++++
 tb/tb_sram_word_responder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared widths and state encodings for the SRAM word responder.
package sram_ctrl_pkg;

   localparam int unsigned SRAM_DW = 16;
   localparam int unsigned SRAM_AW = 18;
   localparam int unsigned WORD_AW = 17;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_LOW  = 2'd1;
   localparam state_t S_HIGH = 2'd2;
   localparam state_t S_DONE = 2'd3;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half wait counter: clears outside an access and wraps to 0 on its terminal count.
module sram_wait_counter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_term
);

   logic [3:0] r_cnt;

   assign o_term = (r_cnt == 4'(WAIT_CYCLES - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_term ? 4'd0 : r_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/sram_word_responder.sv
// Serves 32-bit MEM-stage word requests as two 16-bit SRAM accesses, low half first.
// Optional one-entry read cache enabled by defining SRAM_WORD_CACHE_EN.
module sram_word_responder
   import sram_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N,
   output logic               SRAM_WE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_OE_N
);

   state_t             r_state;
   logic               r_op_wr;
   logic [WORD_AW-1:0] r_waddr;
   logic [31:0]        r_wdata;
   logic [31:0]        r_read_data;

   logic               w_req;
   logic               w_active;
   logic               w_term;
   logic               w_hit;
   logic [WORD_AW-1:0] w_waddr;

   assign w_req    = wr_en | rd_en;
   assign w_active = (r_state == S_LOW) || (r_state == S_HIGH);
   // Out-of-range addresses wrap modulo 2^17 words by truncation.
   assign w_waddr  = WORD_AW'((address - BASE_ADDR) >> 2);

   sram_wait_counter #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait_counter (
      .i_clk (clk),
      .i_rst (rst),
      .i_clr (!w_active),
      .i_en  (w_active),
      .o_term(w_term)
   );

`ifdef SRAM_WORD_CACHE_EN
   logic               r_c_valid;
   logic [WORD_AW-1:0] r_c_tag;
   logic [31:0]        r_c_data;

   assign w_hit     = (r_state == S_IDLE) && rd_en && !wr_en && r_c_valid
                      && (r_c_tag == w_waddr);
   assign read_data = w_hit ? r_c_data : r_read_data;

   // Both reads and writes refresh the entry as their high half completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_c_valid <= 1'b0;
      end else if ((r_state == S_HIGH) && w_term) begin
         r_c_valid <= 1'b1;
         r_c_tag   <= r_waddr;
         r_c_data  <= r_op_wr ? r_wdata : {SRAM_DQ, r_read_data[15:0]};
      end
   end
`else
   assign w_hit     = 1'b0;
   assign read_data = r_read_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_op_wr     <= 1'b0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_read_data <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_hit) begin
                  r_read_data <= read_data;
               end else if (w_req) begin
                  r_op_wr <= wr_en;
                  r_waddr <= w_waddr;
                  r_wdata <= write_data;
                  r_state <= S_LOW;
               end
            end
            S_LOW: begin
               if (w_term) begin
                  if (!r_op_wr) r_read_data[15:0] <= SRAM_DQ;
                  r_state <= S_HIGH;
               end
            end
            S_HIGH: begin
               if (w_term) begin
                  if (!r_op_wr) r_read_data[31:16] <= SRAM_DQ;
                  r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      ready = 1'b0;
      unique case (r_state)
         S_IDLE:  ready = ~w_req | w_hit;
         S_DONE:  ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   assign SRAM_ADDR = {r_waddr, (r_state == S_HIGH)};
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = ~w_active;
   assign SRAM_WE_N = ~(w_active & r_op_wr);
   assign SRAM_OE_N = ~(w_active & ~r_op_wr);
   assign SRAM_DQ   = (w_active && r_op_wr)
                      ? ((r_state == S_HIGH) ? r_wdata[31:16] : r_wdata[15:0])
                      : 16'hzzzz;

endmodule

// File: tb/tb_sram_word_responder.sv
// Directed bench for sram_word_responder with a small behavioural SRAM.
module tb_sram_word_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] address = 32'd0;
   logic [31:0] write_data = 32'd0;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        ub_n, lb_n, we_n, ce_n, oe_n;

   int n_checks = 0;
   int n_errors = 0;

   // SRAM model: 8 halfwords, preload port for test setup
   logic [15:0] mem [0:7];
   logic        pre_we = 1'b0;
   logic [2:0]  pre_idx = 3'd0;
   logic [15:0] pre_val = 16'd0;
   logic [2:0]  m_idx;

   assign m_idx   = 3'(sram_addr);
   assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[m_idx] : 16'hzzzz;

   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_val;
      else if (!ce_n && !we_n) mem[m_idx] <= sram_dq;
   end

   always #5 clk = ~clk;

   sram_word_responder dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .address   (address),
      .write_data(write_data),
      .read_data (read_data),
      .ready     (ready),
      .SRAM_DQ   (sram_dq),
      .SRAM_ADDR (sram_addr),
      .SRAM_UB_N (ub_n),
      .SRAM_LB_N (lb_n),
      .SRAM_WE_N (we_n),
      .SRAM_CE_N (ce_n),
      .SRAM_OE_N (oe_n)
   );

   // Presents a request and waits for ready; cycles = -1 if it never returns.
   task automatic run_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             output int cycles);
      wr_en = wr; rd_en = !wr; address = a; write_data = d; cycles = 0;
      @(negedge clk);
      while (ready !== 1'b1 && cycles < 20) begin
         @(posedge clk); #1; cycles++;
         @(negedge clk);
      end
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
      if (cycles >= 20) cycles = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || read_data !== 32'd0)
         $display("FAIL reset_out ready=%b rdata=%h want 1 00000000", ready, read_data);
      n_checks++;
      if ({ce_n, we_n, oe_n, ub_n, lb_n} !== 5'b11100)
         $display("FAIL reset_strobes ce/we/oe/ub/lb=%b want 11100", {ce_n, we_n, oe_n, ub_n, lb_n});
      if (ready !== 1'b1 || read_data !== 32'd0 || {ce_n, we_n, oe_n, ub_n, lb_n} !== 5'b11100)
         n_errors++;
   endtask

   task automatic test_write();
      logic [17:0] exp_addr;
      logic [15:0] exp_dq;
      @(posedge clk); #1;
      wr_en = 1'b1; address = 32'd1024; write_data = 32'hDEADBEEF;
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b0) begin
         n_errors++; $display("FAIL wr_req_ready got %b want 0", ready);
      end
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (c < 5) begin
            exp_addr = (c <= 2) ? 18'd0 : 18'd1;
            exp_dq   = (c <= 2) ? 16'hBEEF : 16'hDEAD;
            n_checks++;
            if ({ready, ce_n, we_n, oe_n} !== 4'b0001) begin
               n_errors++;
               $display("FAIL wr_strobes c%0d rdy/ce/we/oe=%b want 0001", c, {ready, ce_n, we_n, oe_n});
            end
            n_checks++;
            if (sram_addr !== exp_addr || sram_dq !== exp_dq) begin
               n_errors++;
               $display("FAIL wr_bus c%0d addr=%0d dq=%h want %0d %h", c, sram_addr, sram_dq,
                        exp_addr, exp_dq);
            end
         end else begin
            n_checks++;
            if (ready !== 1'b1 || ce_n !== 1'b1) begin
               n_errors++; $display("FAIL wr_done ready=%b ce_n=%b want 1 1", ready, ce_n);
            end
         end
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin
         n_errors++; $display("FAIL wr_mem got %h %h want BEEF DEAD", mem[0], mem[1]);
      end
   endtask

   task automatic test_read();
      int oe_low = 0;
      @(posedge clk); #1;
      pre_we = 1'b1; pre_idx = 3'd2; pre_val = 16'h1234;
      @(posedge clk); #1;
      pre_idx = 3'd3; pre_val = 16'hABCD;
      @(posedge clk); #1;
      pre_we = 1'b0;
      rd_en = 1'b1; address = 32'd1028;
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b0) begin
         n_errors++; $display("FAIL rd_req_ready got %b want 0", ready);
      end
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (oe_n === 1'b0) oe_low++;
         if (c == 1 || c == 3) begin
            n_checks++;
            if (sram_addr !== ((c == 1) ? 18'd2 : 18'd3)) begin
               n_errors++; $display("FAIL rd_addr c%0d got %0d want %0d", c, sram_addr, c == 1 ? 2 : 3);
            end
         end
      end
      n_checks++;
      if (ready !== 1'b1 || read_data !== 32'hABCD1234) begin
         n_errors++;
         $display("FAIL rd_data ready=%b data=%h want 1 ABCD1234", ready, read_data);
      end
      n_checks++;
      if (oe_low != 4) begin
         n_errors++; $display("FAIL rd_oe_cycles got %0d want 4", oe_low);
      end
      @(posedge clk); #1;
      rd_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      int cyc;
      @(posedge clk); #1;
      run_access(1'b1, 32'd1024, 32'hDEADBEEF, cyc);
      n_checks++;
      if (cyc != 5) begin
         n_errors++; $display("FAIL b2b_wr_latency got %0d want 5", cyc);
      end
      // Load presented in the cycle right after DONE.
      rd_en = 1'b1; address = 32'd1024;
`ifdef SRAM_WORD_CACHE_EN
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || read_data !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL b2b_hit ready=%b data=%h want 1 DEADBEEF", ready, read_data);
      end
`else
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b0) begin
         n_errors++; $display("FAIL b2b_rd_ready got %b want 0", ready);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (ce_n !== 1'b0 || oe_n !== 1'b0) begin
         n_errors++; $display("FAIL b2b_start ce_n=%b oe_n=%b want 0 0", ce_n, oe_n);
      end
      repeat (4) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || read_data !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL b2b_rd_data ready=%b data=%h want 1 DEADBEEF", ready, read_data);
      end
`endif
      @(posedge clk); #1;
      rd_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      wr_en = 1'b1; address = 32'd1024; write_data = 32'h11112222;
      repeat (3) begin
         @(posedge clk); #1;
      end
      n_checks++;
      if (sram_addr !== 18'd1 || we_n !== 1'b0) begin
         n_errors++; $display("FAIL rst_mid_in_high addr=%0d we_n=%b want 1 0", sram_addr, we_n);
      end
      rst = 1'b1; wr_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ready, ce_n, we_n, oe_n} !== 4'b1111 || read_data !== 32'd0) begin
         n_errors++;
         $display("FAIL rst_mid rdy/ce/we/oe=%b data=%h want 1111 00000000",
                  {ready, ce_n, we_n, oe_n}, read_data);
      end
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_checks++;
         if (ready !== 1'b1 || ce_n !== 1'b1) begin
            n_errors++; $display("FAIL idle_%0d ready=%b ce_n=%b want 1 1", i, ready, ce_n);
         end
      end
   endtask

   task automatic test_wrap();
      int cyc;
      @(posedge clk); #1;
      // 2^17 words above waddr 1 aliases onto SRAM halfwords 2/3.
      run_access(1'b0, 32'd1028 + 32'h0008_0000, 32'd0, cyc);
      n_checks++;
      if (cyc < 0 || read_data !== 32'hABCD1234) begin
         n_errors++; $display("FAIL wrap_rd cyc=%0d data=%h want ABCD1234", cyc, read_data);
      end
   endtask

`ifdef SRAM_WORD_CACHE_EN
   task automatic test_cache();
      int cyc;
      @(posedge clk); #1;
      run_access(1'b1, 32'd1024, 32'hDEADBEEF, cyc);
      for (int k = 0; k < 2; k++) begin
         rd_en = 1'b1; address = 32'd1024;
         @(negedge clk);
         n_checks++;
         if (ready !== 1'b1 || ce_n !== 1'b1 || read_data !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL cache_hit_%0d rdy=%b ce_n=%b data=%h want 1 1 DEADBEEF", k, ready,
                     ce_n, read_data);
         end
         @(posedge clk); #1;
         rd_en = 1'b0;
      end
      run_access(1'b1, 32'd1024, 32'h0000_0005, cyc);
      n_checks++;
      if (cyc != 5) begin
         n_errors++; $display("FAIL cache_wr_latency got %0d want 5", cyc);
      end
      rd_en = 1'b1; address = 32'd1024;
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || read_data !== 32'h0000_0005) begin
         n_errors++; $display("FAIL cache_wt_hit rdy=%b data=%h want 1 00000005", ready, read_data);
      end
      @(posedge clk); #1;
      rd_en = 1'b0;
      run_access(1'b0, 32'd1028, 32'd0, cyc);
      n_checks++;
      if (cyc != 5 || read_data !== 32'hABCD1234) begin
         n_errors++; $display("FAIL cache_miss cyc=%0d data=%h want 5 ABCD1234", cyc, read_data);
      end
   endtask
`else
   task automatic test_no_cache();
      int cyc;
      @(posedge clk); #1;
      run_access(1'b1, 32'd1024, 32'hCAFEF00D, cyc);
      run_access(1'b0, 32'd1024, 32'd0, cyc);
      n_checks++;
      if (cyc != 5 || read_data !== 32'hCAFEF00D) begin
         n_errors++; $display("FAIL nocache_rd cyc=%0d data=%h want 5 CAFEF00D", cyc, read_data);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_mid();
      test_idle();
`ifdef SRAM_WORD_CACHE_EN
      test_cache();
`else
      test_no_cache();
`endif
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
